// File: rtl/golden_nonce_tx.sv
// golden_nonce_tx: buffers golden nonces in a small FIFO and sends each one as four UART 8N1 bytes, LSB byte first.
module golden_nonce_tx #(
    parameter int BAUD_DIV = 434,
    parameter int FIFO_AW  = 2
) (
    input  logic        hash_clk,
    input  logic        reset,
    input  logic [31:0] golden_nonce,
    input  logic        golden_nonce_match,
    output logic        uart_tx,
    output logic        tx_busy,
    output logic        fifo_overflow
);
    localparam int DEPTH = 1 << FIFO_AW;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_n;
    logic [31:0] mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0] count;
    logic [31:0] sh, sh_n;
    logic [15:0] baud, baud_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [1:0] byte_cnt, byte_cnt_n;
    logic pop, push, tick, tx_n;
    // count never exceeds DEPTH, so its MSB alone marks a full FIFO
    assign pop  = (state == IDLE) && (count != '0);
    assign push = golden_nonce_match && (!count[FIFO_AW] || pop);
    assign tick = baud == 16'(BAUD_DIV - 1);
    // The shift register moves one bit per data bit, so after 8 bits the next byte sits at bit 0
    always_comb begin
        state_n    = state;
        sh_n       = sh;
        bit_cnt_n  = bit_cnt;
        byte_cnt_n = byte_cnt;
        baud_n     = (state == IDLE || tick) ? '0 : baud + 16'd1;
        case (state)
            IDLE: if (pop) begin
                state_n = START;
                sh_n    = mem[rd_ptr];
            end
            START: if (tick) state_n = DATA;
            DATA: if (tick) begin
                sh_n      = sh >> 1;
                bit_cnt_n = bit_cnt + 3'd1;
                state_n   = (bit_cnt == 3'd7) ? STOP : DATA;
            end
            STOP: if (tick) begin
                state_n    = (byte_cnt == 2'd3) ? IDLE : START;
                byte_cnt_n = byte_cnt + 2'd1;
            end
            default: state_n = IDLE;
        endcase
        tx_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? sh_n[0] : 1'b1;
    end
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            sh            <= '0;
            baud          <= '0;
            bit_cnt       <= '0;
            byte_cnt      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            uart_tx       <= 1'b1;
            tx_busy       <= 1'b0;
            fifo_overflow <= 1'b0;
        end else begin
            state    <= state_n;
            sh       <= sh_n;
            baud     <= baud_n;
            bit_cnt  <= bit_cnt_n;
            byte_cnt <= byte_cnt_n;
            uart_tx  <= tx_n;
            tx_busy  <= (state != IDLE) || (count != '0);
            if (golden_nonce_match && !push) fifo_overflow <= 1'b1;
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
            count <= count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        end
    end
    always_ff @(posedge hash_clk)
        if (push) mem[wr_ptr] <= golden_nonce;
endmodule

// File: tb/tb_golden_nonce_tx.sv
// tb_golden_nonce_tx: directed stimulus with a UART-decoding monitor checked against an expected-nonce queue.
module tb_golden_nonce_tx;
    localparam int BD = 4;
    logic hash_clk = 1'b0;
    logic reset = 1'b1;
    logic golden_nonce_match = 1'b0;
    logic [31:0] golden_nonce = '0;
    logic uart_tx, tx_busy, fifo_overflow;
    int checks = 0;
    int errors = 0;
    int frames = 0;
    int last_gap = 0;
    logic [31:0] exp_q[$];
    logic [31:0] wrap_vals [10] = '{32'h00000000, 32'h11111111, 32'h2468ace0, 32'h13579bdf, 32'hfedcba98,
                                    32'h80000001, 32'h0f0f0f0f, 32'hf0f0f0f0, 32'hcafef00d, 32'hffffffff};

    golden_nonce_tx #(.BAUD_DIV(BD), .FIFO_AW(2)) dut (
        .hash_clk(hash_clk),
        .reset(reset),
        .golden_nonce(golden_nonce),
        .golden_nonce_match(golden_nonce_match),
        .uart_tx(uart_tx),
        .tx_busy(tx_busy),
        .fifo_overflow(fifo_overflow)
    );

    always #5 hash_clk = ~hash_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic strobe(input logic [31:0] v, input bit accept);
        @(negedge hash_clk);
        golden_nonce = v;
        golden_nonce_match = 1'b1;
        if (accept) exp_q.push_back(v);
        @(posedge hash_clk);
        #1 golden_nonce_match = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        repeat (2) @(negedge hash_clk);
        while (tx_busy !== 1'b0 && n < 3000) begin
            @(negedge hash_clk);
            n++;
        end
        check(name, 32'(n < 3000), 1);
        repeat (3) @(negedge hash_clk);
    endtask

    // Decodes the serial line: a frame is 40 bit slots of BD cycles each, starting at the first low sample
    initial begin : monitor
        logic act, ok, cur;
        int p, b, idle;
        logic [31:0] word;
        act = 0; ok = 1; cur = 1; p = 0; b = 0; idle = 0; word = '0;
        forever begin
            @(negedge hash_clk);
            if (reset) begin
                act = 0;
                idle = 0;
            end else if (!act) begin
                if (uart_tx === 1'b0) begin
                    act = 1; p = 0; ok = 1; word = '0;
                    last_gap = idle;
                end else idle++;
            end
            if (act && !reset) begin
                b = (p / BD) % 10;
                if (p % BD == 0) cur = uart_tx;
                else if (uart_tx !== cur) ok = 0;
                if (b == 0 && uart_tx !== 1'b0) ok = 0;
                if (b == 9 && uart_tx !== 1'b1) ok = 0;
                if (b >= 1 && b <= 8 && p % BD == 0) word[(p / (10 * BD)) * 8 + b - 1] = uart_tx;
                p++;
                if (p == 40 * BD) begin
                    act = 0;
                    idle = 0;
                    frames++;
                    check("frame_bits", 32'(ok), 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_unexpected: got %h expected no frame", word);
                    end else check("frame_word", word, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        logic bad;
        repeat (2) @(negedge hash_clk);
        check("rst_tx", uart_tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_ovf", fifo_overflow, 0);
        reset = 1'b0;
        repeat (2) @(negedge hash_clk);
        // single nonce
        f0 = frames;
        strobe(32'h7fbd9207, 1);
        @(negedge hash_clk);
        check("t1_tx_idle_after_push", uart_tx, 1);
        check("t1_busy_after_push", tx_busy, 0);
        @(negedge hash_clk);
        check("t1_tx_start", uart_tx, 0);
        check("t1_busy_rise", tx_busy, 1);
        wait_idle("t1_timeout");
        check("t1_frames", frames - f0, 1);
        check("t1_tx_high", uart_tx, 1);
        check("t1_ovf", fifo_overflow, 0);
        // two strobes three cycles apart
        f0 = frames;
        strobe(32'h00000001, 1);
        repeat (2) @(posedge hash_clk);
        strobe(32'hdeadbeef, 1);
        wait_idle("t2_timeout");
        check("t2_frames", frames - f0, 2);
        check("t2_gap", last_gap, 1);
        // overflow
        f0 = frames;
        for (int i = 1; i <= 5; i++) strobe(i, 1);
        check("t3_ovf_before", fifo_overflow, 0);
        strobe(32'd6, 0);
        check("t3_ovf_set", fifo_overflow, 1);
        wait_idle("t3_timeout");
        check("t3_frames", frames - f0, 5);
        check("t3_ovf_sticky", fifo_overflow, 1);
        @(negedge hash_clk);
        reset = 1'b1;
        @(negedge hash_clk);
        reset = 1'b0;
        @(negedge hash_clk);
        check("t3_ovf_cleared", fifo_overflow, 0);
        // push while full, same edge as a pop
        f0 = frames;
        strobe(32'h11111111, 1);
        strobe(32'h22222222, 1);
        strobe(32'h33333333, 1);
        strobe(32'h44444444, 1);
        strobe(32'h55555555, 1);
        repeat (157) @(posedge hash_clk);
        strobe(32'ha5a5a5a5, 1);
        check("t4_ovf_pop_push", fifo_overflow, 0);
        wait_idle("t4_timeout");
        check("t4_frames", frames - f0, 6);
        check("t4_ovf_end", fifo_overflow, 0);
        // reset during byte 2 data with two entries queued
        f0 = frames;
        strobe(32'h11223344, 1);
        strobe(32'haaaaaaaa, 1);
        strobe(32'hbbbbbbbb, 1);
        repeat (84) @(posedge hash_clk);
        #3;
        check("t5_pre_low", uart_tx, 0);
        reset = 1'b1;
        #1;
        check("t5_rst_tx", uart_tx, 1);
        check("t5_rst_busy", tx_busy, 0);
        exp_q.delete();
        repeat (3) @(negedge hash_clk);
        reset = 1'b0;
        bad = 1'b0;
        repeat (200) begin
            @(negedge hash_clk);
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
        end
        check("t5_no_resume", bad, 0);
        check("t5_frames_none", frames - f0, 0);
        strobe(32'h12345678, 1);
        wait_idle("t5_timeout");
        check("t5_frames", frames - f0, 1);
        // pointer wrap
        f0 = frames;
        for (int i = 0; i < 10; i++) begin
            strobe(wrap_vals[i], 1);
            repeat (199) @(posedge hash_clk);
        end
        wait_idle("t6_timeout");
        check("t6_frames", frames - f0, 10);
        check("t6_ovf", fifo_overflow, 0);
        check("end_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
